// File: rtl/instr_source_seq.sv
// Instruction source sequencer: passes filtered instructions through a registered output
// stage, or expands ucode-tagged instructions into a run of words read from an external ucode store.
module instr_source_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned UAW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             filt_valid,
    input  logic [WIDTH-1:0] filt_instr,
    input  logic             filt_ucode,
    input  logic [UAW-1:0]   filt_uaddr,
    input  logic [UAW-1:0]   filt_ulen,
    output logic             filt_ready,
    output logic [UAW-1:0]   ucode_addr,
    input  logic [WIDTH-1:0] ucode_instr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_instr,
    output logic             out_is_ucode,
    input  logic             out_ready,
    output logic             busy,
    output logic             seq_done
);

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_SEQ  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_instr_q, out_instr_d;
    logic             out_is_ucode_q, out_is_ucode_d;
    logic [UAW-1:0]   uaddr_q, uaddr_d;
    logic [UAW-1:0]   remaining_q, remaining_d;
    logic             seq_done_q, seq_done_d;

    logic ld;
    logic accept;
    logic trigger;

    // Output stage may load when empty or when its current word is being taken.
    assign ld      = !out_valid_q || out_ready;
    assign accept  = (state_q == ST_PASS) && ld && !flush && filt_valid;
    assign trigger = accept && filt_ucode && (filt_ulen != '0);

    // Next-state and output-stage update; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_is_ucode_d = out_is_ucode_q;
        uaddr_d        = uaddr_q;
        remaining_d    = remaining_q;
        seq_done_d     = 1'b0;

        if (flush) begin
            state_d     = ST_PASS;
            out_valid_d = 1'b0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                ST_PASS: begin
                    if (ld) begin
                        if (trigger) begin
                            // Trigger word is consumed without producing output.
                            state_d     = ST_SEQ;
                            uaddr_d     = filt_uaddr;
                            remaining_d = filt_ulen;
                            out_valid_d = 1'b0;
                        end else if (accept) begin
                            out_valid_d    = 1'b1;
                            out_instr_d    = filt_instr;
                            out_is_ucode_d = 1'b0;
                        end else begin
                            out_valid_d = 1'b0;
                        end
                    end
                end
                ST_SEQ: begin
                    if (ld) begin
                        out_valid_d    = 1'b1;
                        out_instr_d    = ucode_instr;
                        out_is_ucode_d = 1'b1;
                        uaddr_d        = uaddr_q + UAW'(1);
                        remaining_d    = remaining_q - UAW'(1);
                        if (remaining_q == UAW'(1)) begin
                            state_d    = ST_PASS;
                            seq_done_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_PASS;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_PASS;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_is_ucode_q <= 1'b0;
            uaddr_q        <= '0;
            remaining_q    <= '0;
            seq_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_is_ucode_q <= out_is_ucode_d;
            uaddr_q        <= uaddr_d;
            remaining_q    <= remaining_d;
            seq_done_q     <= seq_done_d;
        end
    end

    // filt_ready is a same-cycle handshake term; it is forced low while reset is held.
    assign filt_ready   = !rst && (state_q == ST_PASS) && ld && !flush;
    assign ucode_addr   = uaddr_q;
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_is_ucode = out_is_ucode_q;
    assign busy         = (state_q == ST_SEQ);
    assign seq_done     = seq_done_q;

endmodule
